// File: rtl/seg_pkg.sv
// seg_pkg: segment pattern constants shared with the encoder, decoded-value
// codes and the capture FSM state type.
package seg_pkg;

  // Active-low patterns, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [3:0] DIGIT_ERR   = 4'hE;

  typedef enum logic {
    S_TRACK,
    S_HOLD
  } state_t;

endpackage

// File: rtl/segment_capture_if.sv
// segment_capture_if: segment bus input plus the valid/ready result handshake.
// The master side drives the bus and ready; the slave side is the capture block.
interface segment_capture_if;
  logic [6:0] i_Segment;
  logic       i_Ready;
  logic       o_Valid;
  logic [3:0] o_Digit;
  logic       o_Blank;
  logic       o_Error;

  modport master (
    output i_Segment, i_Ready,
    input  o_Valid, o_Digit, o_Blank, o_Error
  );

  modport slave (
    input  i_Segment, i_Ready,
    output o_Valid, o_Digit, o_Blank, o_Error
  );
endinterface

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: combinational lookup of an active-low segment pattern
// into a BCD digit, with blank and illegal flags.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] digit_o,
  output logic       blank_o,
  output logic       error_o
);

  always_comb begin
    digit_o = DIGIT_ERR;
    blank_o = 1'b0;
    error_o = 1'b0;
    case (seg_i)
      SEG_0:     digit_o = 4'd0;
      SEG_1:     digit_o = 4'd1;
      SEG_2:     digit_o = 4'd2;
      SEG_3:     digit_o = 4'd3;
      SEG_4:     digit_o = 4'd4;
      SEG_5:     digit_o = 4'd5;
      SEG_6:     digit_o = 4'd6;
      SEG_7:     digit_o = 4'd7;
      SEG_8:     digit_o = 4'd8;
      SEG_9:     digit_o = 4'd9;
      SEG_BLANK: begin
        digit_o = DIGIT_BLANK;
        blank_o = 1'b1;
      end
      default:   error_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/segment_capture.sv
// segment_capture: glitch-filtered seven-segment receiver that offers each newly
// settled pattern once. Define SEGMENT_CAPTURE_SYNC_EN for an asynchronous source.
module segment_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input logic              i_Clk,
  input logic              i_Rst,
  segment_capture_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(STABLE_CYCLES);

  logic [6:0]    segIn;
  logic [6:0]    sample_q, sample_d;
  logic [CW-1:0] count_q, count_d;
  logic [6:0]    last_q, pend_q;
  state_t        state_q;
  logic          valid_q, blank_q, error_q;
  logic [3:0]    digit_q;
  logic [3:0]    decDigit;
  logic          decBlank, decError;
  logic          settled;

`ifdef SEGMENT_CAPTURE_SYNC_EN
  logic [6:0] sync1_q, sync2_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1_q <= SEG_BLANK;
      sync2_q <= SEG_BLANK;
    end else begin
      sync1_q <= bus.i_Segment;
      sync2_q <= sync1_q;
    end
  end

  assign segIn = sync2_q;
`else
  assign segIn = bus.i_Segment;
`endif

  always_comb begin
    sample_d = segIn;
    if (segIn != sample_q)
      count_d = '0;
    else if (count_q == COUNT_MAX)
      count_d = COUNT_MAX;
    else
      count_d = count_q + CW'(1);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sample_q <= SEG_BLANK;
      count_q  <= '0;
    end else begin
      sample_q <= sample_d;
      count_q  <= count_d;
    end
  end

  seg_pattern_decode u_decode (
    .seg_i   (sample_q),
    .digit_o (decDigit),
    .blank_o (decBlank),
    .error_o (decError)
  );

  // Looking at the next count lets the offer appear on the edge the pattern settles
  assign settled = (count_d == COUNT_MAX) && (sample_q != last_q);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= S_TRACK;
      last_q  <= SEG_BLANK;
      pend_q  <= SEG_BLANK;
      valid_q <= 1'b0;
      digit_q <= DIGIT_BLANK;
      blank_q <= 1'b1;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        S_TRACK: begin
          if (settled) begin
            pend_q  <= sample_q;
            digit_q <= decDigit;
            blank_q <= decBlank;
            error_q <= decError;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.i_Ready) begin
            last_q  <= pend_q;
            valid_q <= 1'b0;
            state_q <= S_TRACK;
          end
        end
        default: state_q <= S_TRACK;
      endcase
    end
  end

  assign bus.o_Valid = valid_q;
  assign bus.o_Digit = digit_q;
  assign bus.o_Blank = blank_q;
  assign bus.o_Error = error_q;

endmodule

// File: tb/tb_segment_capture.sv
// tb_segment_capture: table-driven decode checks, hand-written handshake
// sequences and randomized traffic against a sample-history reference model.
module tb_segment_capture;

  localparam int STABLE = 4;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] REF_MAP [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef struct {
    logic [6:0] pattern;
    logic [3:0] digit;
    logic       blank;
    logic       error;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  segment_capture_if busIf ();

  segment_capture #(.STABLE_CYCLES(STABLE)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (busIf)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;
  int validCycles = 0;
  logic [3:0] seenDigit = 4'h0;

  // Reference model state: recent sample history and the offered result
  logic [6:0] hist[$];
  logic       mValid;
  logic [3:0] mDigit;
  logic       mBlank, mError;
  logic [6:0] mLast, mPend;

  function automatic void decodeRef(input logic [6:0] p, output logic [3:0] d,
                                    output logic b, output logic e);
    d = 4'hE;
    b = 1'b0;
    e = 1'b1;
    if (p == BLANK) begin
      d = 4'hF;
      b = 1'b1;
      e = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      if (p == REF_MAP[i]) begin
        d = 4'(i);
        e = 1'b0;
      end
    end
  endfunction

  // A pattern counts as settled once the last STABLE+1 samples agree; reset acts as one blank sample
  function automatic void modelEdge(input logic r, input logic [6:0] s, input logic rdy);
    bit stable;
    if (r) begin
      hist.delete();
      hist.push_back(BLANK);
      mValid = 1'b0;
      mDigit = 4'hF;
      mBlank = 1'b1;
      mError = 1'b0;
      mLast  = BLANK;
      mPend  = BLANK;
    end else begin
      hist.push_back(s);
      if (hist.size() > STABLE + 1) void'(hist.pop_front());
      stable = (hist.size() == STABLE + 1);
      foreach (hist[i]) if (hist[i] != s) stable = 1'b0;
      if (mValid) begin
        if (rdy) begin
          mLast  = mPend;
          mValid = 1'b0;
        end
      end else if (stable && s != mLast) begin
        mPend  = s;
        decodeRef(s, mDigit, mBlank, mError);
        mValid = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    modelEdge(rst, busIf.i_Segment, busIf.i_Ready);
    #1;
    testsRun++;
    if ({busIf.o_Valid, busIf.o_Digit, busIf.o_Blank, busIf.o_Error} !==
        {mValid, mDigit, mBlank, mError}) begin
      testsFailed++;
      $display("[TB] FAIL model t=%0t got v=%b d=%h b=%b e=%b want v=%b d=%h b=%b e=%b",
               $time, busIf.o_Valid, busIf.o_Digit, busIf.o_Blank, busIf.o_Error,
               mValid, mDigit, mBlank, mError);
    end
    if (busIf.o_Valid === 1'b1) begin
      validCycles++;
      seenDigit = busIf.o_Digit;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [6:0] seg, input logic rdy, input int n);
    rst = r;
    busIf.i_Segment = seg;
    busIf.i_Ready = rdy;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string name, input logic v, input logic [3:0] d,
                             input logic b, input logic e);
    testsRun++;
    if ({busIf.o_Valid, busIf.o_Digit, busIf.o_Blank, busIf.o_Error} !== {v, d, b, e}) begin
      testsFailed++;
      $display("[TB] FAIL %s got v=%b d=%h b=%b e=%b want v=%b d=%h b=%b e=%b", name,
               busIf.o_Valid, busIf.o_Digit, busIf.o_Blank, busIf.o_Error, v, d, b, e);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    testsRun++;
    if (got != want) begin
      testsFailed++;
      $display("[TB] FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic waitValid(input string name, input int maxCycles);
    int n = 0;
    while (busIf.o_Valid !== 1'b1 && n < maxCycles) begin
      tick();
      n++;
    end
    if (busIf.o_Valid !== 1'b1) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s timeout got o_Valid=%b want 1 within %0d cycles",
               name, busIf.o_Valid, maxCycles);
    end
  endtask

  initial begin
    vec_t vecs[15];
    logic [6:0] curSeg;

    vecs[0]  = '{7'b1000000, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{7'b1111001, 4'd1, 1'b0, 1'b0};
    vecs[2]  = '{7'b0100100, 4'd2, 1'b0, 1'b0};
    vecs[3]  = '{7'b0110000, 4'd3, 1'b0, 1'b0};
    vecs[4]  = '{7'b0011001, 4'd4, 1'b0, 1'b0};
    vecs[5]  = '{7'b0010010, 4'd5, 1'b0, 1'b0};
    vecs[6]  = '{7'b0000010, 4'd6, 1'b0, 1'b0};
    vecs[7]  = '{7'b1111000, 4'd7, 1'b0, 1'b0};
    vecs[8]  = '{7'b0000000, 4'd8, 1'b0, 1'b0};
    vecs[9]  = '{7'b0010000, 4'd9, 1'b0, 1'b0};
    vecs[10] = '{7'b1111111, 4'hF, 1'b1, 1'b0};
    vecs[11] = '{7'b1111110, 4'hE, 1'b0, 1'b1};
    vecs[12] = '{7'b0000001, 4'hE, 1'b0, 1'b1};
    vecs[13] = '{7'b1110111, 4'hE, 1'b0, 1'b1};
    vecs[14] = '{7'b0101010, 4'hE, 1'b0, 1'b1};

    // Reset with a live pattern on the bus
    applyStimulus(1'b1, 7'b0100100, 1'b0, 2);
    checkOutput("reset", 1'b0, 4'hF, 1'b1, 1'b0);

    // Basic: one single-cycle offer on edge 5, no repeats
    applyStimulus(1'b0, 7'b0100100, 1'b1, STABLE);
    checkOutput("basic_pre", 1'b0, 4'hF, 1'b1, 1'b0);
    applyStimulus(1'b0, 7'b0100100, 1'b1, 1);
    checkOutput("basic_offer", 1'b1, 4'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'b0100100, 1'b1, 1);
    checkOutput("basic_ack", 1'b0, 4'd2, 1'b0, 1'b0);
    validCycles = 0;
    applyStimulus(1'b0, 7'b0100100, 1'b1, 20);
    checkCount("basic_norepeat", validCycles, 0);

    // Glitch: a short-lived 3 is filtered out
    validCycles = 0;
    applyStimulus(1'b0, 7'b0110000, 1'b1, 3);
    applyStimulus(1'b0, 7'b0011001, 1'b1, 12);
    checkCount("glitch_events", validCycles, 1);
    checkCount("glitch_digit", int'(seenDigit), 4);

    // Backpressure: result frozen while the bus moves on
    applyStimulus(1'b0, 7'b0000000, 1'b0, 6);
    checkOutput("bp_offer", 1'b1, 4'd8, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'b1111000, 1'b0, 10);
    checkOutput("bp_frozen", 1'b1, 4'd8, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'b1111000, 1'b1, 1);
    checkOutput("bp_gap", 1'b0, 4'd8, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'b1111000, 1'b1, 1);
    checkOutput("bp_next", 1'b1, 4'd7, 1'b0, 1'b0);

    // Illegal then blank
    applyStimulus(1'b0, 7'b0101010, 1'b1, 1);
    waitValid("illegal_wait", 10);
    checkOutput("illegal", 1'b1, 4'hE, 1'b0, 1'b1);
    applyStimulus(1'b0, BLANK, 1'b1, 1);
    waitValid("blank_wait", 10);
    checkOutput("blank", 1'b1, 4'hF, 1'b1, 1'b0);

    // Reset while holding digit 5, then re-offer after release
    applyStimulus(1'b0, 7'b0010010, 1'b1, 1);
    applyStimulus(1'b0, 7'b0010010, 1'b0, 0);
    waitValid("hold5_wait", 10);
    checkOutput("hold5", 1'b1, 4'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, 7'b0010010, 1'b0, 1);
    checkOutput("rst_hold", 1'b0, 4'hF, 1'b1, 1'b0);
    applyStimulus(1'b0, 7'b0010010, 1'b0, STABLE);
    checkOutput("rst_wait", 1'b0, 4'hF, 1'b1, 1'b0);
    applyStimulus(1'b0, 7'b0010010, 1'b0, 1);
    checkOutput("rst_reoffer", 1'b1, 4'd5, 1'b0, 1'b0);

    // Decode table
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, vecs[i].pattern, 1'b1, 1);
      waitValid($sformatf("table%0d_wait", i), 12);
      checkOutput($sformatf("table%0d", i), 1'b1, vecs[i].digit, vecs[i].blank, vecs[i].error);
    end

    // Randomized traffic against the model
    curSeg = BLANK;
    for (int i = 0; i < 800; i++) begin
      int pick;
      if ($urandom_range(0, 99) < 30) begin
        pick = $urandom_range(0, 11);
        if (pick < 10) curSeg = REF_MAP[pick];
        else if (pick == 10) curSeg = BLANK;
        else curSeg = 7'($urandom);
      end
      applyStimulus(logic'($urandom_range(0, 99) == 0), curSeg,
                    logic'($urandom_range(0, 3) != 0), 1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout got no finish want finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
